// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - operand/result bundle for the bit-serial adder/subtractor
//
// Purpose: groups the request, operand and result signals of serial_addsub.
//   master modport: the operand source / result consumer (drives start, rst, mode, CIN, A, B).
//   slave modport : the serial_addsub datapath (drives S, COUT, busy, done, ovf).
// Signals:
//   start  operation request          rst   synchronous abort
//   mode   0 = add, 1 = subtract      CIN   carry-in / borrow-in
//   A, B   WIDTH-bit operands         S     WIDTH-bit result
//   COUT   final carry (sub: 1 = no borrow)
//   busy   operation in progress      done  one-cycle result-valid pulse
//   ovf    signed overflow, present only when SERIAL_ADDSUB_OVF_EN is defined
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             rst;
    logic             mode;
    logic             CIN;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic             COUT;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;

    modport master (
        output start, rst, mode, CIN, A, B,
        input  S, COUT, busy, done, ovf
    );

    modport slave (
        input  start, rst, mode, CIN, A, B,
        output S, COUT, busy, done, ovf
    );
`else
    modport master (
        output start, rst, mode, CIN, A, B,
        input  S, COUT, busy, done
    );

    modport slave (
        input  start, rst, mode, CIN, A, B,
        output S, COUT, busy, done
    );
`endif
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial WIDTH-bit adder/subtractor with FSM control
//
// Purpose: captures A/B on start, processes one bit per clock (LSB first) through
// a single full-adder slice and a carry flip-flop, then presents S/COUT with a
// one-cycle done pulse.  Subtraction is A + ~B + ~CIN, so COUT=1 means no borrow.
// Ports:
//   CLK   rising-edge clock
//   NRST  asynchronous active-low reset
//   bus   serial_addsub_if.slave (start, rst, mode, CIN, A, B -> S, COUT, busy, done[, ovf])
// Optional feature: define SERIAL_ADDSUB_OVF_EN to add bus.ovf, the signed
// two's-complement overflow flag (carry into MSB XOR carry out of MSB).
// Legal WIDTH range: 2..32.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic          CLK,
    input  logic          NRST,
    serial_addsub_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    // Single full-adder slice on the current LSBs.
    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    always_comb begin
        sum_bit    = op_a[0] ^ op_b[0] ^ carry;
        carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        res_next   = {sum_bit, res[WIDTH-1:1]};
        last_bit   = (cnt == CNT_W'(WIDTH - 1));
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q;
    assign bus.ovf = ovf_q;
`endif

    assign bus.S    = s_q;
    assign bus.COUT = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state  <= IDLE;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (bus.rst) begin
            // Abort: the partial result is dropped, visible results are held.
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_a   <= bus.A;
                        op_b   <= bus.mode ? ~bus.B : bus.B;
                        carry  <= bus.mode ? ~bus.CIN : bus.CIN;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    carry <= carry_next;
                    res   <= res_next;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // The result registers load from the final shifted value
                        // on this edge, so S/COUT are already valid while done is high.
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        s_q    <= res_next;
                        cout_q <= carry_next;
`ifdef SERIAL_ADDSUB_OVF_EN
                        ovf_q  <= carry ^ carry_next;
`endif
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    // Encoding 2'b11 is unreachable; recover to IDLE.
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - scoreboard testbench for serial_addsub (WIDTH=8)
module tb_serial_addsub;
    localparam int WIDTH = 8;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;
    int   cyc;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         id;
    } exp_t;

    exp_t exp_q[$];

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .CLK  (clk),
        .NRST (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, expv);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (nrst) begin
            if (bus.busy && bus.done) chk("busy_and_done", 32'd1, 32'd0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("op%0d_S", e.id), {24'd0, bus.S}, {24'd0, e.s});
                    chk($sformatf("op%0d_COUT", e.id), {31'd0, bus.COUT}, {31'd0, e.c});
`ifdef SERIAL_ADDSUB_OVF_EN
                    chk($sformatf("op%0d_ovf", e.id), {31'd0, bus.ovf}, {31'd0, e.o});
`endif
                end
            end
        end
    end

    task automatic push(input logic [7:0] s, input logic c, input logic o, input int id);
        exp_t e;
        e.s = s; e.c = c; e.o = o; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic wait_busy(input logic lvl, input string nm);
        int n;
        n = 0;
        while (bus.busy !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Issues one operation from IDLE and checks busy length and done position.
    task automatic run_op(input int id, input logic m, input logic c,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.CIN = c; bus.A = a; bus.B = b;
        push(es, ec, eo, id);
        @(negedge clk);
        // Operands must already be captured; scramble them.
        bus.start = 1'b0; bus.A = ~a; bus.B = ~b; bus.mode = ~m; bus.CIN = ~c;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("op%0d_busy_cycles", id), n, WIDTH);
        chk($sformatf("op%0d_done_pulse", id), {31'd0, bus.done}, 32'd1);
        @(negedge clk);
        chk($sformatf("op%0d_done_one_cycle", id), {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int t0, t1, t2;
        checks = 0; errors = 0; cyc = 0;
        nrst = 1'b0;
        bus.start = 1'b0; bus.rst = 1'b0; bus.mode = 1'b0; bus.CIN = 1'b0;
        bus.A = '0; bus.B = '0;
        repeat (3) @(negedge clk);
        chk("reset_S", {24'd0, bus.S}, 32'd0);
        chk("reset_COUT", {31'd0, bus.COUT}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        //      id mode cin  A      B      S      COUT ovf
        run_op(1, 0, 0, 8'hFF, 8'h01, 8'h00, 1, 0);
        run_op(2, 1, 0, 8'h05, 8'h07, 8'hFE, 0, 0);
        run_op(3, 1, 0, 8'h07, 8'h05, 8'h02, 1, 0);
        run_op(4, 0, 1, 8'h7F, 8'h01, 8'h81, 0, 1);
        run_op(5, 0, 0, 8'h10, 8'h20, 8'h30, 0, 0);
        run_op(6, 0, 0, 8'h80, 8'h80, 8'h00, 1, 1);
        run_op(7, 1, 0, 8'h80, 8'h01, 8'h7F, 1, 1);
        run_op(8, 1, 1, 8'h10, 8'h05, 8'h0A, 1, 0);

        // Abort in RUN cycle 4: no done, prior result held.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.CIN = 1'b0; bus.A = 8'h12; bus.B = 8'h34;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.rst = 1'b1;
        @(negedge clk);
        bus.rst = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_S_held", {24'd0, bus.S}, 32'h0A);
        chk("abort_COUT_held", {31'd0, bus.COUT}, 32'd1);

        // rst and start together: rst wins.
        bus.start = 1'b1; bus.rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.rst = 1'b0;
        chk("rst_beats_start", {31'd0, bus.busy}, 32'd0);
        run_op(9, 0, 0, 8'h12, 8'h34, 8'h46, 0, 0);

        // Start held high, operands changed while busy.
        @(negedge clk);
        bus.mode = 1'b0; bus.CIN = 1'b0; bus.A = 8'h01; bus.B = 8'h02; bus.start = 1'b1;
        push(8'h03, 0, 0, 10);
        wait_busy(1'b1, "b2b_first");
        t0 = cyc;
        bus.A = 8'h03; bus.B = 8'h04;
        push(8'h07, 0, 0, 11);
        wait_busy(1'b0, "b2b_end1");
        wait_busy(1'b1, "b2b_second");
        t1 = cyc;
        chk("b2b_gap1", t1 - t0, WIDTH + 2);
        bus.A = 8'h05; bus.B = 8'h06;
        push(8'h0B, 0, 0, 12);
        wait_busy(1'b0, "b2b_end2");
        wait_busy(1'b1, "b2b_third");
        t2 = cyc;
        chk("b2b_gap2", t2 - t1, WIDTH + 2);
        bus.start = 1'b0;
        wait_busy(1'b0, "b2b_end3");
        repeat (3) @(negedge clk);

        // NRST mid-RUN clears everything immediately.
        bus.start = 1'b1; bus.A = 8'hAA; bus.B = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("nrst_S", {24'd0, bus.S}, 32'd0);
        chk("nrst_COUT", {31'd0, bus.COUT}, 32'd0);
        chk("nrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("nrst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        run_op(13, 1, 0, 8'h07, 8'h05, 8'h02, 1, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
